result_checker: RTL
===================

// Module: result_checker
// PURPOSE
//  Synthesizable, parametrised end-of-program result checker for the CHIP bench.
//  Snoops N_CH D-cache write channels into a shadow memory while the program runs.
//  When PC reaches END_PC it compares every shadow word against a golden image and
//  counts mismatches. It also captures the first mismatch, enforces a cycle timeout
//  and reports pass/fail.
// PARAMETERS
//  ADDR_W      8     word address width; DEPTH = 2**ADDR_W words
//  DATA_W      32    word width
//  N_CH        2     number of snooped write channels
//  END_PC      400   run ends when pc >= END_PC (unsigned)
//  TIMEOUT     2500  max RUN cycles before forced report
//  ERR_W       9     error counter width, saturating
//  SWAP_REPORT 1     1: first_err_exp/got byte-reversed (little-endian view); 0: raw
// PORTS
//  clk             in   1             clock, all logic on posedge
//  rst             in   1             synchronous, active-high reset
//  init_en         in   1             image load strobe (IDLE only)
//  init_sel        in   1             0: shadow memory, 1: golden memory
//  init_addr       in   ADDR_W        load address
//  init_data       in   DATA_W        load data
//  go              in   1             IDLE->RUN
//  snp_wen         in   N_CH          per-channel write enable
//  snp_addr        in   N_CH*ADDR_W   channel k at [k*ADDR_W +: ADDR_W]
//  snp_data        in   N_CH*DATA_W   channel k at [k*DATA_W +: DATA_W]
//  pc              in   32            processor PC
//  cycle_cnt       out  16            RUN cycles elapsed, saturating
//  error_num       out  ERR_W         mismatch count
//  first_err_valid out  1             a mismatch has been captured
//  first_err_addr  out  ADDR_W        address of lowest-index mismatch
//  first_err_exp   out  DATA_W        golden word at that address
//  first_err_got   out  DATA_W        shadow word at that address
//  timeout         out  1             report was forced by TIMEOUT
//  finish          out  1             check complete; stays high until rst
//  pass            out  1             finish & ~timeout & error_num==0
// BEHAVIOUR
//  Reset: state=IDLE. All outputs are 0: cycle_cnt, error_num, first_err_*, timeout,
//   finish, pass. Memory contents are NOT cleared, so a reset mid-run keeps the images.
//  States: IDLE -> RUN -> CHECK -> REPORT -> END.
//   IDLE:   init_en writes the selected memory, 1 write/cycle. go=1 -> RUN next cycle.
//           If init_en and go are high in the same cycle, the write is applied first.
//   RUN:    cycle_cnt increments each cycle. Each snp_wen[k] writes the shadow memory.
//           Same-address writes in one cycle: the highest k wins.
//           Priority: pc>=END_PC -> CHECK, else cycle_cnt==TIMEOUT-1 -> REPORT, timeout<=1.
//           A snoop write in the cycle pc reaches END_PC is still committed.
//   CHECK:  index i runs 0..DEPTH-1, one word/cycle, read combinationally.
//           If shadow[i]!=golden[i]: error_num++ (saturates at 2**ERR_W-1).
//           On the first mismatch only, latch first_err_*.
//           At i==DEPTH-1 -> REPORT. CHECK lasts exactly DEPTH cycles.
//   REPORT: 1 cycle; finish<=1, pass<=~timeout&(error_num==0). finish/pass are seen the
//           cycle after REPORT. A timed-out run skips CHECK (error_num stays 0, pass=0).
//   END:    hold all outputs.
//  Writes are ignored outside their state: init outside IDLE, snoop outside RUN.
//  Index i wraps are impossible by construction. Its width is ADDR_W+1, so no overflow.
//  go outside IDLE is ignored.
// STRUCTURE
//  checker_pkg: state enum (S_IDLE..S_END), DEPTH localparam helper, byte_rev function.
//  Sub-module checker_mem: shadow+golden register arrays, one init port, N_CH snoop
//   ports with index-priority, two async read ports at a common index.
//  The top holds the FSM, counters, first-error capture and the report logic.
// TESTING
//  1 Load golden==shadow, go, no snoops, pc=END_PC at cycle 10
//    -> finish after DEPTH+2 cycles; error_num=0; pass=1.
//  2 RUN: ch0 writes addr 5 = 0x11223344, which golden does not have
//    -> error_num=1; first_err_addr=5; first_err_got=0x44332211 (SWAP_REPORT=1).
//  3 ch0 and ch1 both write addr 7 in one cycle; ch1 value matches golden
//    -> error_num=0 (ch1 wins).
//  4 pc stays <END_PC -> timeout=1, finish at cycle TIMEOUT+1, pass=0, error_num=0.
//  5 Golden differs from shadow at all 256 words -> error_num saturates at 511? No:
//    256 fits -> error_num=256; with ERR_W=4 -> error_num=15.
//  6 Assert rst during CHECK -> next cycle all outputs are 0, state=IDLE.
//    go with pc>=END_PC -> rechecks the retained images.

Source files
------------

// File: rtl/result_checker_pkg.sv
// Shared types and helpers for the end-of-program result checker.
package result_checker_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_CHECK  = 3'd2,
    S_REPORT = 3'd3,
    S_END    = 3'd4
  } state_t;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  // Reverses the lowest nbytes bytes of word; shifting avoids variable part-selects.
  function automatic logic [63:0] byte_rev(input logic [63:0] word, input int nbytes);
    logic [63:0] src;
    logic [63:0] dst;
    src = word;
    dst = '0;
    for (int b = 0; b < 8; b++) begin
      if (b < nbytes) begin
        dst = {dst[55:0], src[7:0]};
        src = src >> 8;
      end
    end
    return dst;
  endfunction

endpackage

// File: rtl/result_checker_if.sv
// Bundle of image-load, snoop, PC and report signals between bench and checker.
interface result_checker_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int N_CH   = 2,
  parameter int ERR_W  = 9
) ();
  import result_checker_pkg::*;

  logic                     init_en;
  logic                     init_sel;
  logic [ADDR_W-1:0]        init_addr;
  logic [DATA_W-1:0]        init_data;
  logic                     go;
  logic [N_CH-1:0]          snp_wen;
  logic [N_CH*ADDR_W-1:0]   snp_addr;
  logic [N_CH*DATA_W-1:0]   snp_data;
  logic [31:0]              pc;
  logic [15:0]              cycle_cnt;
  logic [ERR_W-1:0]         error_num;
  logic                     first_err_valid;
  logic [ADDR_W-1:0]        first_err_addr;
  logic [DATA_W-1:0]        first_err_exp;
  logic [DATA_W-1:0]        first_err_got;
  logic                     timeout;
  logic                     finish;
  logic                     pass;
  state_t                   state;

  // Handshake: go is a one-cycle request honoured only in IDLE; finish rises once
  // the report is latched and stays high (with all results frozen) until rst.
  modport master (
    output init_en, init_sel, init_addr, init_data, go, snp_wen, snp_addr, snp_data, pc,
    input  cycle_cnt, error_num, first_err_valid, first_err_addr, first_err_exp,
           first_err_got, timeout, finish, pass, state
  );

  modport slave (
    input  init_en, init_sel, init_addr, init_data, go, snp_wen, snp_addr, snp_data, pc,
    output cycle_cnt, error_num, first_err_valid, first_err_addr, first_err_exp,
           first_err_got, timeout, finish, pass, state
  );

endinterface

// File: rtl/result_checker_mem.sv
// Shadow and golden word arrays: one init port, N_CH prioritised snoop ports,
// and two asynchronous read ports sharing one index.
module result_checker_mem
  import result_checker_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int N_CH   = 2
) (
  input  logic                   clk,
  input  logic                   init_we,
  input  logic                   init_sel,
  input  logic [ADDR_W-1:0]      init_addr,
  input  logic [DATA_W-1:0]      init_data,
  input  logic [N_CH-1:0]        snp_we,
  input  logic [N_CH*ADDR_W-1:0] snp_addr,
  input  logic [N_CH*DATA_W-1:0] snp_data,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [DATA_W-1:0]      shadow_rd,
  output logic [DATA_W-1:0]      golden_rd
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] shadow_mem [DEPTH];
  logic [DATA_W-1:0] golden_mem [DEPTH];

  // Later channels assign last, so the highest index wins on an address clash.
  always_ff @(posedge clk) begin
    if (init_we && !init_sel) begin
      shadow_mem[init_addr] <= init_data;
    end
    for (int k = 0; k < N_CH; k++) begin
      if (snp_we[k]) begin
        shadow_mem[snp_addr[k*ADDR_W +: ADDR_W]] <= snp_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (init_we && init_sel) begin
      golden_mem[init_addr] <= init_data;
    end
  end

  assign shadow_rd = shadow_mem[rd_addr];
  assign golden_rd = golden_mem[rd_addr];

endmodule

// File: rtl/result_checker.sv
// End-of-program checker: snoops writes during RUN, compares shadow vs golden
// word by word, and reports error count, first mismatch, timeout and pass.
module result_checker
  import result_checker_pkg::*;
#(
  parameter int          ADDR_W      = 8,
  parameter int          DATA_W      = 32,
  parameter int          N_CH        = 2,
  parameter int unsigned END_PC      = 400,
  parameter int          TIMEOUT     = 2500,
  parameter int          ERR_W       = 9,
  parameter bit          SWAP_REPORT = 1'b1
) (
  input logic             clk,
  input logic             rst,
  result_checker_if.slave bus
);

  localparam int DEPTH = depth_of(ADDR_W);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   idx_q;
  logic [15:0]       cycle_q;
  logic [ERR_W-1:0]  err_q;
  logic              fev_q;
  logic [ADDR_W-1:0] faddr_q;
  logic [DATA_W-1:0] fexp_q, fgot_q;
  logic              timeout_q, finish_q, pass_q;

  logic              pc_end, run_expired, last_idx, mismatch;
  logic [DATA_W-1:0] shadow_rd, golden_rd, exp_view, got_view;

  assign pc_end      = bus.pc >= 32'(END_PC);
  assign run_expired = cycle_q == 16'(TIMEOUT - 1);
  assign last_idx    = idx_q == (ADDR_W + 1)'(DEPTH - 1);
  assign mismatch    = shadow_rd != golden_rd;

  result_checker_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .N_CH   (N_CH)
  ) u_mem (
    .clk       (clk),
    .init_we   ((state_q == S_IDLE) && bus.init_en),
    .init_sel  (bus.init_sel),
    .init_addr (bus.init_addr),
    .init_data (bus.init_data),
    .snp_we    ((state_q == S_RUN) ? bus.snp_wen : '0),
    .snp_addr  (bus.snp_addr),
    .snp_data  (bus.snp_data),
    .rd_addr   (idx_q[ADDR_W-1:0]),
    .shadow_rd (shadow_rd),
    .golden_rd (golden_rd)
  );

  // Report words are shown in little-endian byte order when SWAP_REPORT is set.
  assign exp_view = SWAP_REPORT ? DATA_W'(byte_rev(64'(golden_rd), DATA_W / 8)) : golden_rd;
  assign got_view = SWAP_REPORT ? DATA_W'(byte_rev(64'(shadow_rd), DATA_W / 8)) : shadow_rd;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (bus.go) state_d = S_RUN;
      S_RUN: begin
        if (pc_end)           state_d = S_CHECK;
        else if (run_expired) state_d = S_REPORT;
      end
      S_CHECK:  if (last_idx) state_d = S_REPORT;
      S_REPORT: state_d = S_END;
      S_END:    state_d = S_END;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      cycle_q   <= '0;
      err_q     <= '0;
      fev_q     <= 1'b0;
      faddr_q   <= '0;
      fexp_q    <= '0;
      fgot_q    <= '0;
      timeout_q <= 1'b0;
      finish_q  <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_RUN: begin
          idx_q <= '0;
          if (cycle_q != '1) cycle_q <= cycle_q + 1'b1;
          if (!pc_end && run_expired) timeout_q <= 1'b1;
        end
        S_CHECK: begin
          idx_q <= idx_q + 1'b1;
          if (mismatch) begin
            if (err_q != '1) err_q <= err_q + 1'b1;
            if (!fev_q) begin
              fev_q   <= 1'b1;
              faddr_q <= idx_q[ADDR_W-1:0];
              fexp_q  <= exp_view;
              fgot_q  <= got_view;
            end
          end
        end
        S_REPORT: begin
          finish_q <= 1'b1;
          pass_q   <= ~timeout_q & (err_q == '0);
        end
        default: ;
      endcase
    end
  end

  assign bus.cycle_cnt       = cycle_q;
  assign bus.error_num       = err_q;
  assign bus.first_err_valid = fev_q;
  assign bus.first_err_addr  = faddr_q;
  assign bus.first_err_exp   = fexp_q;
  assign bus.first_err_got   = fgot_q;
  assign bus.timeout         = timeout_q;
  assign bus.finish          = finish_q;
  assign bus.pass            = pass_q;
  assign bus.state           = state_q;

endmodule
